// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser.
// Coin encodings double as the output code driven on the coin bus.
// Default inventory is what reset restores.
package change_pkg;

  typedef enum logic [2:0] {
    COIN_NONE = 3'b000,
    COIN_CIR  = 3'b001,
    COIN_TRI  = 3'b011,
    COIN_PENT = 3'b101
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE
  } state_t;

  localparam int unsigned PENT_VAL = 5;
  localparam int unsigned TRI_VAL  = 3;
  localparam int unsigned CIR_VAL  = 1;

  localparam logic [1:0] INV_DEFAULT = 2'd3;

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake, restock and status bundle of the change dispenser.
// master = the environment driving requests and coin_ready.
// slave  = the dispenser itself.
interface change_dispenser_if #(
  parameter int AMT_W = 4
);

  logic             load;
  logic [1:0]       load_pent;
  logic [1:0]       load_tri;
  logic [1:0]       load_cir;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             coin_valid;
  logic [2:0]       coin;
  logic             coin_ready;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] remaining;
  logic             exact;
  logic             timeout;
  logic [1:0]       pent_left;
  logic [1:0]       tri_left;
  logic [1:0]       cir_left;

  modport master (
    output load, load_pent, load_tri, load_cir, start, amount, coin_ready,
    input  coin_valid, coin, busy, done, remaining, exact, timeout,
           pent_left, tri_left, cir_left
  );

  modport slave (
    input  load, load_pent, load_tri, load_cir, start, amount, coin_ready,
    output coin_valid, coin, busy, done, remaining, exact, timeout,
           pent_left, tri_left, cir_left
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest in-stock coin not exceeding rem.
// Purely combinational, zero latency.
// No handshake; the caller decides when the pick is consumed.
module coin_select
  import change_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic [AMT_W-1:0] rem_i,
  input  logic [1:0]       pent_i,
  input  logic [1:0]       tri_i,
  input  logic [1:0]       cir_i,
  output coin_t            coin_o,
  output logic [AMT_W-1:0] rem_next_o
);

  // Priority pick; the count and rem guards mean no underflow is possible.
  always_comb begin
    coin_o     = COIN_NONE;
    rem_next_o = rem_i;
    if (rem_i >= AMT_W'(PENT_VAL) && pent_i != 2'd0) begin
      coin_o     = COIN_PENT;
      rem_next_o = rem_i - AMT_W'(PENT_VAL);
    end else if (rem_i >= AMT_W'(TRI_VAL) && tri_i != 2'd0) begin
      coin_o     = COIN_TRI;
      rem_next_o = rem_i - AMT_W'(TRI_VAL);
    end else if (rem_i >= AMT_W'(CIR_VAL) && cir_i != 2'd0) begin
      coin_o     = COIN_CIR;
      rem_next_o = rem_i - AMT_W'(CIR_VAL);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: holds coin inventory, pays out owed change one coin per handshake.
// Latency: start to done = accepted coins + stalled cycles + 2 (2 when nothing fits).
// Backpressure: coin held stable while coin_ready is low; optional stall abort via CHANGE_TIMEOUT_EN.
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input logic               clock,
  input logic               reset,
  change_dispenser_if.slave bus
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [1:0]       pent_q, pent_d;
  logic [1:0]       tri_q, tri_d;
  logic [1:0]       cir_q, cir_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic             exact_q, exact_d;

  coin_t            sel_coin;
  logic [AMT_W-1:0] sel_rem;
  logic             coin_vld;

`ifdef CHANGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;
  logic             stall_hit;

  // The current stalled cycle is the one that brings the count to the limit.
  assign stall_hit = (stall_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  coin_select #(.AMT_W(AMT_W)) u_coin_select (
    .rem_i      (rem_q),
    .pent_i     (pent_q),
    .tri_i      (tri_q),
    .cir_i      (cir_q),
    .coin_o     (sel_coin),
    .rem_next_o (sel_rem)
  );

  // Next-state, datapath updates and the coin handshake.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pent_d      = pent_q;
    tri_d       = tri_q;
    cir_d       = cir_q;
    remaining_d = remaining_q;
    exact_d     = exact_q;
    coin_vld    = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
    stall_d     = stall_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        // Restock beats a simultaneous start, which is simply dropped.
        if (bus.load) begin
          pent_d = bus.load_pent;
          tri_d  = bus.load_tri;
          cir_d  = bus.load_cir;
        end else if (bus.start) begin
          rem_d   = bus.amount;
          state_d = DISPENSE;
`ifdef CHANGE_TIMEOUT_EN
          stall_d   = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      DISPENSE: begin
        if (sel_coin == COIN_NONE) begin
          // Results are captured on the way into DONE so they line up with the done pulse.
          state_d     = DONE;
          remaining_d = rem_q;
          exact_d     = (rem_q == '0);
        end else begin
          coin_vld = 1'b1;
          if (bus.coin_ready) begin
            rem_d = sel_rem;
            case (sel_coin)
              COIN_PENT: pent_d = pent_q - 2'd1;
              COIN_TRI:  tri_d  = tri_q - 2'd1;
              COIN_CIR:  cir_d  = cir_q - 2'd1;
              default:   ;
            endcase
`ifdef CHANGE_TIMEOUT_EN
            stall_d = '0;
          end else if (stall_hit) begin
            // Abort: the stalled coin stays in stock and in remaining.
            state_d     = DONE;
            timeout_d   = 1'b1;
            remaining_d = rem_q;
            exact_d     = (rem_q == '0);
          end else begin
            stall_d = stall_q + 1'b1;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      pent_q      <= INV_DEFAULT;
      tri_q       <= INV_DEFAULT;
      cir_q       <= INV_DEFAULT;
      remaining_q <= '0;
      exact_q     <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
      stall_q     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      pent_q      <= pent_d;
      tri_q       <= tri_d;
      cir_q       <= cir_d;
      remaining_q <= remaining_d;
      exact_q     <= exact_d;
`ifdef CHANGE_TIMEOUT_EN
      stall_q     <= stall_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Outside DISPENSE the picker still sees stale rem, so the coin code is gated.
  assign bus.coin_valid = coin_vld;
  assign bus.coin       = coin_vld ? sel_coin : COIN_NONE;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.remaining  = remaining_q;
  assign bus.exact      = exact_q;
  assign bus.pent_left  = pent_q;
  assign bus.tri_left   = tri_q;
  assign bus.cir_left   = cir_q;

`ifdef CHANGE_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  // No stall limit in this build; a non-negative limit makes this a constant 0.
  localparam logic TIMEOUT_TIE = (TIMEOUT_CYC < 0);
  assign bus.timeout = TIMEOUT_TIE;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized transactions.
// Reference model computes coin counts from the greedy rule with plain arithmetic.
// Define CHANGE_TIMEOUT_EN to also exercise the stall abort.
module tb_change_dispenser;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  int   m_p = 3, m_t = 3, m_c = 3;

  change_dispenser_if #(.AMT_W(4)) cd ();

  change_dispenser #(.AMT_W(4), .TIMEOUT_CYC(15)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (cd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic do_load(input int p, input int t, input int c);
    @(negedge clk);
    cd.load = 1'b1; cd.load_pent = 2'(p); cd.load_tri = 2'(t); cd.load_cir = 2'(c);
    @(negedge clk);
    cd.load = 1'b0;
    m_p = p; m_t = t; m_c = c;
    checks++;
    if (cd.pent_left !== 2'(p) || cd.tri_left !== 2'(t) || cd.cir_left !== 2'(c))
      $display("FAIL load_inv got %0d/%0d/%0d exp %0d/%0d/%0d", cd.pent_left, cd.tri_left, cd.cir_left, p, t, c);
    else passed++;
  endtask

  // mode 0: always ready; mode 1: random ready with at most 3 consecutive stalls.
  // disturb: pulse load/start every busy cycle, which must be ignored.
  task automatic run_txn(input int amt, input int mode, input bit disturb);
    int np, nt, nc, r, cyc, stalls, accepts, consec;
    bit seen, rdy;
    logic [2:0] expq[$];
    r  = amt;
    np = min2(m_p, r / 5); r = r - 5 * np;
    nt = min2(m_t, r / 3); r = r - 3 * nt;
    nc = min2(m_c, r);     r = r - nc;
    for (int i = 0; i < np; i++) expq.push_back(3'b101);
    for (int i = 0; i < nt; i++) expq.push_back(3'b011);
    for (int i = 0; i < nc; i++) expq.push_back(3'b001);
    @(negedge clk);
    cd.amount = 4'(amt); cd.start = 1'b1; cd.coin_ready = 1'b0;
    @(negedge clk);
    cd.start = 1'b0;
    cyc = 1; stalls = 0; accepts = 0; consec = 0; seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      if (cd.done) begin
        seen = 1'b1;
      end else begin
        if (cd.coin_valid) begin
          checks++;
          if (expq.size() == 0) $display("FAIL coin_extra got %b exp none (amount %0d)", cd.coin, amt);
          else if (cd.coin !== expq[0]) $display("FAIL coin_seq got %b exp %b (amount %0d)", cd.coin, expq[0], amt);
          else passed++;
          rdy = (mode == 0) || (consec >= 3) || ($urandom_range(0, 2) != 0);
          cd.coin_ready = rdy;
          if (rdy) begin
            if (expq.size() > 0) void'(expq.pop_front());
            accepts++; consec = 0;
          end else begin
            stalls++; consec++;
          end
        end else begin
          cd.coin_ready = 1'($urandom_range(0, 1));
        end
        if (disturb) begin
          cd.load = 1'b1; cd.load_pent = 2'd0; cd.load_tri = 2'd0; cd.load_cir = 2'd0;
          cd.start = 1'b1; cd.amount = 4'd15;
        end
        @(negedge clk);
        cyc++;
      end
    end
    cd.load = 1'b0; cd.start = 1'b0; cd.coin_ready = 1'b0;
    m_p = m_p - np; m_t = m_t - nt; m_c = m_c - nc;
    checks++;
    if (!seen || cyc != np + nt + nc + stalls + 2)
      $display("FAIL latency got done=%0b at cycle %0d exp cycle %0d (amount %0d)", seen, cyc, np + nt + nc + stalls + 2, amt);
    else passed++;
    checks++;
    if (cd.remaining !== 4'(r)) $display("FAIL remaining got %0d exp %0d", cd.remaining, r); else passed++;
    checks++;
    if (cd.exact !== (r == 0)) $display("FAIL exact got %b exp %b", cd.exact, (r == 0)); else passed++;
    checks++;
    if (cd.timeout !== 1'b0 || cd.busy !== 1'b1) $display("FAIL done_flags got timeout=%b busy=%b exp 0/1", cd.timeout, cd.busy); else passed++;
    checks++;
    if (cd.pent_left !== 2'(m_p) || cd.tri_left !== 2'(m_t) || cd.cir_left !== 2'(m_c))
      $display("FAIL inv_after got %0d/%0d/%0d exp %0d/%0d/%0d", cd.pent_left, cd.tri_left, cd.cir_left, m_p, m_t, m_c);
    else passed++;
    @(negedge clk);
    checks++;
    if (cd.done !== 1'b0 || cd.busy !== 1'b0) $display("FAIL done_pulse got done=%b busy=%b exp 0/0", cd.done, cd.busy); else passed++;
  endtask

  task automatic test_reset;
    checks++;
    if (cd.coin_valid !== 1'b0 || cd.coin !== 3'b000 || cd.busy !== 1'b0 || cd.done !== 1'b0)
      $display("FAIL reset_ctrl got vld=%b coin=%b busy=%b done=%b exp 0/000/0/0", cd.coin_valid, cd.coin, cd.busy, cd.done);
    else passed++;
    checks++;
    if (cd.remaining !== 4'd0 || cd.exact !== 1'b0 || cd.timeout !== 1'b0)
      $display("FAIL reset_status got rem=%0d exact=%b timeout=%b exp 0/0/0", cd.remaining, cd.exact, cd.timeout);
    else passed++;
    checks++;
    if (cd.pent_left !== 2'd3 || cd.tri_left !== 2'd3 || cd.cir_left !== 2'd3)
      $display("FAIL reset_inv got %0d/%0d/%0d exp 3/3/3", cd.pent_left, cd.tri_left, cd.cir_left);
    else passed++;
  endtask

  task automatic test_amount_13;
    run_txn(13, 0, 1'b0);
    checks++;
    if (cd.pent_left !== 2'd1 || cd.tri_left !== 2'd2 || cd.cir_left !== 2'd3 || cd.exact !== 1'b1)
      $display("FAIL amt13 got %0d/%0d/%0d exact=%b exp 1/2/3 exact=1", cd.pent_left, cd.tri_left, cd.cir_left, cd.exact);
    else passed++;
  endtask

  task automatic test_load_7;
    do_load(1, 0, 1);
    run_txn(7, 0, 1'b0);
    checks++;
    if (cd.remaining !== 4'd1 || cd.exact !== 1'b0 || cd.pent_left !== 2'd0 || cd.cir_left !== 2'd0)
      $display("FAIL load7 got rem=%0d exact=%b p=%0d c=%0d exp 1/0/0/0", cd.remaining, cd.exact, cd.pent_left, cd.cir_left);
    else passed++;
  endtask

  task automatic test_zero;
    run_txn(0, 0, 1'b0);
    checks++;
    if (cd.exact !== 1'b1 || cd.remaining !== 4'd0) $display("FAIL zero got exact=%b rem=%0d exp 1/0", cd.exact, cd.remaining);
    else passed++;
  endtask

  task automatic test_stall_8;
    do_load(3, 3, 3);
    @(negedge clk);
    cd.amount = 4'd8; cd.start = 1'b1; cd.coin_ready = 1'b0;
    @(negedge clk);
    cd.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cd.coin_valid !== 1'b1 || cd.coin !== 3'b101 || cd.pent_left !== 2'd3)
        $display("FAIL stall_hold got vld=%b coin=%b p=%0d exp 1/101/3 (cycle %0d)", cd.coin_valid, cd.coin, cd.pent_left, i);
      else passed++;
      @(negedge clk);
    end
    cd.coin_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cd.coin_valid !== 1'b1 || cd.coin !== 3'b011) $display("FAIL stall_next got vld=%b coin=%b exp 1/011", cd.coin_valid, cd.coin);
    else passed++;
    @(negedge clk);
    cd.coin_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (cd.done !== 1'b1 || cd.remaining !== 4'd0 || cd.exact !== 1'b1 || cd.pent_left !== 2'd2 || cd.tri_left !== 2'd2)
      $display("FAIL stall_done got done=%b rem=%0d exact=%b p=%0d t=%0d exp 1/0/1/2/2", cd.done, cd.remaining, cd.exact, cd.pent_left, cd.tri_left);
    else passed++;
    m_p = 2; m_t = 2; m_c = 3;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    @(negedge clk);
    cd.amount = 4'd15; cd.start = 1'b1; cd.coin_ready = 1'b1;
    @(negedge clk);
    cd.start = 1'b0;
    @(negedge clk);
    checks++;
    if (cd.pent_left !== 2'd1 || cd.coin_valid !== 1'b1) $display("FAIL rstmid_accept got p=%0d vld=%b exp 1/1", cd.pent_left, cd.coin_valid);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_p = 3; m_t = 3; m_c = 3;
    checks++;
    if (cd.busy !== 1'b0 || cd.coin_valid !== 1'b0 || cd.pent_left !== 2'd3 || cd.tri_left !== 2'd3 || cd.cir_left !== 2'd3)
      $display("FAIL rstmid_state got busy=%b vld=%b inv=%0d/%0d/%0d exp 0/0/3/3/3", cd.busy, cd.coin_valid, cd.pent_left, cd.tri_left, cd.cir_left);
    else passed++;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cd.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    cd.coin_ready = 1'b0;
    checks++;
    if (saw_done) $display("FAIL rstmid_done got done pulse exp none"); else passed++;
  endtask

  task automatic test_ignore_busy;
    do_load(3, 3, 3);
    run_txn(9, 1, 1'b1);
  endtask

  task automatic test_load_start;
    @(negedge clk);
    cd.load = 1'b1; cd.load_pent = 2'd2; cd.load_tri = 2'd1; cd.load_cir = 2'd0;
    cd.start = 1'b1; cd.amount = 4'd5;
    @(negedge clk);
    cd.load = 1'b0; cd.start = 1'b0;
    m_p = 2; m_t = 1; m_c = 0;
    checks++;
    if (cd.busy !== 1'b0 || cd.pent_left !== 2'd2 || cd.tri_left !== 2'd1 || cd.cir_left !== 2'd0)
      $display("FAIL load_start got busy=%b inv=%0d/%0d/%0d exp 0/2/1/0", cd.busy, cd.pent_left, cd.tri_left, cd.cir_left);
    else passed++;
    @(negedge clk);
    checks++;
    if (cd.busy !== 1'b0 || cd.done !== 1'b0) $display("FAIL load_start_idle got busy=%b done=%b exp 0/0", cd.busy, cd.done);
    else passed++;
  endtask

`ifdef CHANGE_TIMEOUT_EN
  task automatic test_timeout;
    int  cyc;
    bit  seen;
    do_load(3, 3, 3);
    @(negedge clk);
    cd.amount = 4'd9; cd.start = 1'b1; cd.coin_ready = 1'b0;
    @(negedge clk);
    cd.start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      if (cd.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!seen || cyc != 16) $display("FAIL timeout_latency got done=%b cycle %0d exp cycle 16", seen, cyc); else passed++;
    checks++;
    if (cd.timeout !== 1'b1 || cd.remaining !== 4'd9 || cd.exact !== 1'b0 || cd.pent_left !== 2'd3)
      $display("FAIL timeout_status got to=%b rem=%0d exact=%b p=%0d exp 1/9/0/3", cd.timeout, cd.remaining, cd.exact, cd.pent_left);
    else passed++;
    @(negedge clk);
    run_txn(2, 0, 1'b0);
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_txn(int'($urandom_range(0, 15)), 1, (i % 7) == 3);
    end
  endtask

  initial begin
    rst = 1'b1;
    cd.load = 1'b0; cd.load_pent = 2'd0; cd.load_tri = 2'd0; cd.load_cir = 2'd0;
    cd.start = 1'b0; cd.amount = 4'd0; cd.coin_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_amount_13();
    test_load_7();
    test_zero();
    test_stall_8();
    test_reset_mid();
    test_ignore_busy();
    test_load_start();
`ifdef CHANGE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
